encoder8_rr: RTL and testbench
==============================

Name: encoder8_rr

Overview:
- Sequential 8-to-3 round-robin request encoder with a valid/ready output; it is the encode direction of the one-hot select path.
- Collects single-cycle one-hot or multi-hot request pulses into a pending mask.
- Issues one 3-bit index per handshake, fair across sources.
- Sits between event sources (interrupt/stall lines, etc.) and control logic that consumes a binary index.

Parameters:
- ROUND_ROBIN, 1, 1 = rotating priority starting after the last issued index; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_set  in  8  one-cycle request pulses; bit i sets pending[i].
- flush  in  1  synchronous clear of pending mask and output stage.
- out_ready  in  1  consumer accepts out_idx this cycle.
- out_valid  out  1  out_idx/out_onehot hold a valid grant.
- out_idx  out  3  binary index of the granted request.
- out_onehot  out  8  registered 1<<out_idx; all zero when out_valid=0.
- pending  out  8  current pending mask; excludes the index held in the output stage.
- dup  out  1  one-cycle pulse: some req_set bit was already set in pending.

Behaviour:
- Reset: all outputs zero.
  - out_valid=0, out_idx=0, out_onehot=0, pending=0, dup=0.
  - Internal rotation pointer ptr=0.
  - FSM=S_IDLE.
- FSM has two states: S_IDLE (out_valid=0) and S_VALID (out_valid=1).
- load = (S_IDLE or (S_VALID and out_ready)) and (pending != 0).
  - On load: select index k from the registered pending mask (never from same-cycle req_set).
  - out_idx<=k, out_onehot<=1<<k, out_valid<=1, pending[k] cleared.
- Transitions:
  - S_IDLE -> S_VALID on load.
  - S_VALID -> S_IDLE on out_ready with pending==0.
  - S_VALID stays on !out_ready (hold) or on out_ready with load (back-to-back).
- Hold: while out_valid=1 and out_ready=0, out_idx and out_onehot are stable.
- Selection, ROUND_ROBIN=1:
  - First set bit scanning ptr, ptr+1, ... modulo 8.
  - After each load, ptr <= k+1 mod 8 (k=7 wraps to 0).
  - ptr changes only on load.
- Selection, ROUND_ROBIN=0: lowest set bit; ptr is unused.
- Pending update: pending_next = (pending & ~load_clear) | req_set.
  - A set wins over a load-clear of the same bit in the same cycle, so the bit stays pending and is reissued later.
- A req_set bit equal to the index held in the output stage is legal: it re-pends that index.
- dup = |(req_set & pending), registered, one-cycle pulse.
- Latency:
  - req_set at edge n -> pending at n -> load at n+1 -> out_valid high after edge n+1 (2 cycles).
  - Back-to-back grants: 1 per cycle while out_ready=1 and pending!=0.
- flush (when rst=0) forces next state:
  - pending=0, out_valid=0, out_onehot=0, dup=0, FSM=S_IDLE.
  - ptr is unchanged; same-cycle req_set is dropped.
  - A handshake in the flush cycle counts as consumed.
- rst has priority over flush and all other inputs, including mid-handshake.
- Empty: pending=0 in S_IDLE -> remains idle, out_idx holds its last value, out_onehot=0.
- All 8 pending: issues 8 grants in rotation order with no starvation.

Decomposition:
- Package encoder8_pkg:
  - typedef idx_t = logic [2:0].
  - typedef onehot_t = logic [7:0].
  - enum state_t {S_IDLE, S_VALID}.
  - constant NUM_REQ=8.
- Sub-module rr_pick8 (combinational):
  - Inputs: mask[7:0], start idx_t.
  - Outputs: found, idx_t sel.
  - Implemented as a doubled-mask scan; with start tied to 0 it serves fixed-priority mode.

Test Plan:
- Reset then req_set=8'b0000_0100 for 1 cycle -> out_valid=1 two cycles later, out_idx=2, out_onehot=8'h04; out_ready=1 -> out_valid=0 next cycle, pending=0.
- ROUND_ROBIN=1, req_set=8'hFF one cycle, out_ready=1 always -> out_idx sequence 0,1,2,3,4,5,6,7 on consecutive cycles; then req_set=8'h81 -> grants 0 then 7 (ptr wrapped to 0); ROUND_ROBIN=0 with the same 8'h81 -> grants 0 then 7.
- ROUND_ROBIN=1, after grant 5, req_set=8'h28 -> grant 3 is never before 5... precisely: ptr=6, so out_idx=3 only after any index 6/7 pending; with 8'h28 only -> grants 3 then 5 (scan 6,7,0,..3 first).
- Backpressure: out_valid=1, out_idx=4, out_ready=0 for 5 cycles while req_set=8'h10 pulses -> out_idx stays 4, pending=8'h10, dup=1 on the second pulse only; release -> 4 reissued next.
- flush asserted with pending=8'h66, out_valid=1, same-cycle req_set=8'h01 -> next cycle pending=0, out_valid=0, out_onehot=0; no grant of 0 follows.
- rst asserted mid-burst (pending=8'h3C, out_valid=1) -> next cycle all outputs 0, ptr=0; subsequent req_set=8'h80 -> out_idx=7.

Source files
------------

// File: rtl/encoder8_pkg.sv
// rtl/encoder8_pkg.sv - shared types and constants for the 8-to-3 round-robin request encoder
package encoder8_pkg;

   localparam int NUM_REQ = 8;

   typedef logic [2:0] idx_t;
   typedef logic [7:0] onehot_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_VALID = 1'b1
   } state_t;

endpackage

// File: rtl/encoder8_rr_if.sv
// rtl/encoder8_rr_if.sv - request/grant bundle between event sources, encoder and consumer
interface encoder8_rr_if;
   import encoder8_pkg::*;

   onehot_t req_set;
   logic    flush;
   logic    out_ready;
   logic    out_valid;
   idx_t    out_idx;
   onehot_t out_onehot;
   onehot_t pending;
   logic    dup;

   // environment side: raises requests and consumes grants
   modport master (
      output req_set, flush, out_ready,
      input  out_valid, out_idx, out_onehot, pending, dup
   );

   // encoder side
   modport slave (
      input  req_set, flush, out_ready,
      output out_valid, out_idx, out_onehot, pending, dup
   );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational first-set-bit search starting at a rotating index
module rr_pick8
   import encoder8_pkg::*;
(
   input  onehot_t mask,
   input  idx_t    start,
   output logic    found,
   output idx_t    sel
);

   onehot_t rot;
   idx_t    off;

   // rotate the mask so bit 0 is the start position, find the lowest set bit, rotate back
   always_comb begin
      found = 1'b0;
      off   = '0;
      rot   = onehot_t'({mask, mask} >> start);
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = idx_t'(i);
         end
      end
      sel = start + off;
   end

endmodule

// File: rtl/encoder8_rr.sv
// rtl/encoder8_rr.sv - collects request pulses and issues one fair 3-bit index per handshake
module encoder8_rr
   import encoder8_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
)
(
   input logic          clk,
   input logic          rst,
   encoder8_rr_if.slave bus
);

   state_t  state;
   idx_t    ptr;
   onehot_t pending_q;
   logic    valid_q;
   idx_t    idx_q;
   onehot_t onehot_q;
   logic    dup_q;

   idx_t    start;
   logic    found;
   idx_t    sel;
   logic    load;
   onehot_t load_clear;

   // fixed-priority mode always scans from index 0
   assign start = (ROUND_ROBIN != 0) ? ptr : '0;

   rr_pick8 u_pick (
      .mask  (pending_q),
      .start (start),
      .found (found),
      .sel   (sel)
   );

   // a new grant is taken whenever the output stage is empty or being emptied this cycle
   always_comb begin
      load       = 1'b0;
      load_clear = '0;
      if (((state == S_IDLE) || ((state == S_VALID) && bus.out_ready)) && found) begin
         load       = 1'b1;
         load_clear = onehot_t'(1) << sel;
      end
   end

   // pending mask, output stage, rotation pointer and FSM; reset beats flush beats normal flow
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         pending_q <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         onehot_q  <= '0;
         dup_q     <= 1'b0;
      end else if (bus.flush) begin
         state     <= S_IDLE;
         pending_q <= '0;
         valid_q   <= 1'b0;
         onehot_q  <= '0;
         dup_q     <= 1'b0;
      end else begin
         dup_q     <= |(bus.req_set & pending_q);
         // a same-cycle set wins over the load clear so the bit is reissued later
         pending_q <= (pending_q & ~load_clear) | bus.req_set;
         if (load) begin
            state    <= S_VALID;
            valid_q  <= 1'b1;
            idx_q    <= sel;
            onehot_q <= load_clear;
            ptr      <= sel + 3'd1;
         end else if ((state == S_VALID) && bus.out_ready) begin
            state    <= S_IDLE;
            valid_q  <= 1'b0;
            onehot_q <= '0;
         end
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_idx    = idx_q;
   assign bus.out_onehot = onehot_q;
   assign bus.pending    = pending_q;
   assign bus.dup        = dup_q;

endmodule

// File: tb/tb_encoder8_rr.sv
// tb/tb_encoder8_rr.sv - scoreboard bench for round-robin and fixed-priority encoder instances
module tb_encoder8_rr;
   import encoder8_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   idx_t q_rr[$];
   idx_t q_fp[$];

   encoder8_rr_if bus_rr ();
   encoder8_rr_if bus_fp ();

   encoder8_rr #(.ROUND_ROBIN(1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
   encoder8_rr #(.ROUND_ROBIN(0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard monitor for the round-robin instance
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_rr.out_valid && bus_rr.out_ready) begin
            if (q_rr.size() == 0) begin
               chk("rr_unexpected_grant", {29'd0, bus_rr.out_idx}, 32'hFFFF_FFFF);
            end else begin
               idx_t e;
               e = q_rr.pop_front();
               chk("rr_idx", {29'd0, bus_rr.out_idx}, {29'd0, e});
               chk("rr_onehot", {24'd0, bus_rr.out_onehot}, {24'd0, onehot_t'(1) << e});
            end
         end else if (!bus_rr.out_valid) begin
            chk("rr_onehot_idle", {24'd0, bus_rr.out_onehot}, 32'd0);
         end
      end
   end

   // scoreboard monitor for the fixed-priority instance
   always @(negedge clk) begin
      if (!rst && bus_fp.out_valid && bus_fp.out_ready) begin
         if (q_fp.size() == 0) begin
            chk("fp_unexpected_grant", {29'd0, bus_fp.out_idx}, 32'hFFFF_FFFF);
         end else begin
            idx_t e;
            e = q_fp.pop_front();
            chk("fp_idx", {29'd0, bus_fp.out_idx}, {29'd0, e});
            chk("fp_onehot", {24'd0, bus_fp.out_onehot}, {24'd0, onehot_t'(1) << e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_rr.req_set = '0; bus_rr.flush = 1'b0; bus_rr.out_ready = 1'b0;
      bus_fp.req_set = '0; bus_fp.flush = 1'b0; bus_fp.out_ready = 1'b0;
      step(2);
      rst = 1'b0;
      chk("rst_valid",   {31'd0, bus_rr.out_valid}, 32'd0);
      chk("rst_idx",     {29'd0, bus_rr.out_idx}, 32'd0);
      chk("rst_onehot",  {24'd0, bus_rr.out_onehot}, 32'd0);
      chk("rst_pending", {24'd0, bus_rr.pending}, 32'd0);
      chk("rst_dup",     {31'd0, bus_rr.dup}, 32'd0);

      // single request, two-cycle latency
      bus_rr.req_set = 8'h04; q_rr.push_back(3'd2);
      step(1); bus_rr.req_set = '0;
      chk("t1_pending", {24'd0, bus_rr.pending}, 32'h04);
      chk("t1_valid_early", {31'd0, bus_rr.out_valid}, 32'd0);
      step(1);
      chk("t1_valid", {31'd0, bus_rr.out_valid}, 32'd1);
      chk("t1_idx", {29'd0, bus_rr.out_idx}, 32'd2);
      chk("t1_onehot", {24'd0, bus_rr.out_onehot}, 32'h04);
      bus_rr.out_ready = 1'b1;
      step(1);
      chk("t1_valid_after", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t1_pending_after", {24'd0, bus_rr.pending}, 32'd0);

      // fresh pointer, all eight requests back to back
      rst = 1'b1; step(1); rst = 1'b0;
      bus_rr.req_set = 8'hFF;
      for (int k = 0; k < 8; k++) q_rr.push_back(idx_t'(k));
      step(1); bus_rr.req_set = '0;
      step(9);
      chk("t2_drained_valid", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t2_drained_queue", q_rr.size(), 32'd0);

      // pointer wrapped to 0 after granting 7
      bus_rr.req_set = 8'h81; q_rr.push_back(3'd0); q_rr.push_back(3'd7);
      step(1); bus_rr.req_set = '0;
      step(3);
      chk("t2b_queue", q_rr.size(), 32'd0);

      // grant 5 leaves ptr=6, then 8'h28 gives 3 before 5
      bus_rr.req_set = 8'h20; q_rr.push_back(3'd5);
      step(1); bus_rr.req_set = '0;
      step(2);
      bus_rr.req_set = 8'h28; q_rr.push_back(3'd3); q_rr.push_back(3'd5);
      step(1); bus_rr.req_set = '0;
      step(3);
      chk("t3_valid", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t3_queue", q_rr.size(), 32'd0);

      // backpressure hold with duplicate detection
      bus_rr.out_ready = 1'b0;
      bus_rr.req_set = 8'h10; q_rr.push_back(3'd4);
      step(1); bus_rr.req_set = '0;
      step(1);
      chk("t4_idx", {29'd0, bus_rr.out_idx}, 32'd4);
      chk("t4_pending0", {24'd0, bus_rr.pending}, 32'd0);
      bus_rr.req_set = 8'h10; step(1); bus_rr.req_set = '0;
      chk("t4_dup_first", {31'd0, bus_rr.dup}, 32'd0);
      chk("t4_pending1", {24'd0, bus_rr.pending}, 32'h10);
      step(1);
      chk("t4_hold_idx_a", {29'd0, bus_rr.out_idx}, 32'd4);
      bus_rr.req_set = 8'h10; step(1); bus_rr.req_set = '0;
      chk("t4_dup_second", {31'd0, bus_rr.dup}, 32'd1);
      step(1);
      chk("t4_dup_clear", {31'd0, bus_rr.dup}, 32'd0);
      chk("t4_hold_onehot", {24'd0, bus_rr.out_onehot}, 32'h10);
      step(1);
      chk("t4_hold_idx_b", {29'd0, bus_rr.out_idx}, 32'd4);
      chk("t4_hold_valid", {31'd0, bus_rr.out_valid}, 32'd1);
      bus_rr.out_ready = 1'b1; q_rr.push_back(3'd4);
      step(2);
      chk("t4_valid_end", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t4_queue", q_rr.size(), 32'd0);

      // flush with a held grant, pending work and a same-cycle request
      bus_rr.out_ready = 1'b0;
      bus_rr.req_set = 8'h66; q_rr.push_back(3'd5);
      step(1); bus_rr.req_set = '0;
      step(1);
      bus_rr.req_set = 8'h20; step(1); bus_rr.req_set = '0;
      chk("t5_pending", {24'd0, bus_rr.pending}, 32'h66);
      chk("t5_idx", {29'd0, bus_rr.out_idx}, 32'd5);
      bus_rr.flush = 1'b1; bus_rr.req_set = 8'h01; bus_rr.out_ready = 1'b1;
      step(1);
      bus_rr.flush = 1'b0; bus_rr.req_set = '0;
      chk("t5_flush_pending", {24'd0, bus_rr.pending}, 32'd0);
      chk("t5_flush_valid", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t5_flush_onehot", {24'd0, bus_rr.out_onehot}, 32'd0);
      step(3);
      chk("t5_no_grant", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t5_queue", q_rr.size(), 32'd0);

      // reset in the middle of a burst
      bus_rr.out_ready = 1'b0;
      bus_rr.req_set = 8'h3C; step(1);
      bus_rr.req_set = 8'h04; step(1);
      bus_rr.req_set = '0;
      chk("t6_pending", {24'd0, bus_rr.pending}, 32'h3C);
      chk("t6_valid", {31'd0, bus_rr.out_valid}, 32'd1);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("t6_rst_valid", {31'd0, bus_rr.out_valid}, 32'd0);
      chk("t6_rst_idx", {29'd0, bus_rr.out_idx}, 32'd0);
      chk("t6_rst_pending", {24'd0, bus_rr.pending}, 32'd0);
      chk("t6_rst_onehot", {24'd0, bus_rr.out_onehot}, 32'd0);
      bus_rr.out_ready = 1'b1;
      bus_rr.req_set = 8'h84; q_rr.push_back(3'd2); q_rr.push_back(3'd7);
      step(1); bus_rr.req_set = '0;
      step(3);
      bus_rr.req_set = 8'h80; q_rr.push_back(3'd7);
      step(1); bus_rr.req_set = '0;
      step(1);
      chk("t6_idx7", {29'd0, bus_rr.out_idx}, 32'd7);
      step(1);
      chk("t6_queue", q_rr.size(), 32'd0);

      // fixed-priority instance
      bus_fp.out_ready = 1'b1;
      bus_fp.req_set = 8'h81; q_fp.push_back(3'd0); q_fp.push_back(3'd7);
      step(1); bus_fp.req_set = '0;
      step(3);
      bus_fp.req_set = 8'h0C; q_fp.push_back(3'd2); q_fp.push_back(3'd3);
      step(1); bus_fp.req_set = '0;
      step(3);
      bus_fp.req_set = 8'h32;
      q_fp.push_back(3'd1); q_fp.push_back(3'd4); q_fp.push_back(3'd5);
      step(1); bus_fp.req_set = '0;
      step(4);
      chk("fp_valid_end", {31'd0, bus_fp.out_valid}, 32'd0);
      chk("fp_queue", q_fp.size(), 32'd0);
      chk("rr_queue_final", q_rr.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
